// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N up/down counter family.
package counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } cnt_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Values are carried in 33 bits so a modulus of 2**32 stays representable.
    function automatic logic [32:0] clamp_load(input logic [32:0] val, input logic [32:0] modulus);
        return (val >= modulus) ? (modulus - 33'd1) : val;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and terminal detection for a modulo-MODULUS counter.
module updown_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             at_terminal
);

    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 64'd1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] step_v;

    // NOTE: every output is given a value on every path, so no latch is inferred.
    always_comb begin
        q_ext       = {1'b0, q};
        at_terminal = (up == DIR_UP) ? (q_ext == MAX_V) : (q_ext == '0);
        step_v      = (up == DIR_UP) ? (q_ext + 1'b1) : (q_ext - 1'b1);
        if (at_terminal) begin
            next_q = (up == DIR_UP) ? '0 : MAX_V[WIDTH-1:0];
        end else begin
            next_q = step_v[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised modulo-N up/down counter with load, wrap pulse and one-shot halt.
// Define UPDOWN_COUNTER_CASCADE_EN to add the cin/cout chaining ports.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             done
`ifdef UPDOWN_COUNTER_CASCADE_EN
    ,
    input  logic             cin,
    output logic             cout
`endif
);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
        $fatal(1, "updown_counter_mod: WIDTH or MODULUS out of range");
    end

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] next_q;
    logic             at_terminal;
    logic             eff_en;

    updown_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q           (q_q),
        .up          (up),
        .next_q      (next_q),
        .at_terminal (at_terminal)
    );

`ifdef UPDOWN_COUNTER_CASCADE_EN
    assign eff_en = en & cin;
    assign cout   = cin & en & at_terminal & (state_q != HALT);
`else
    assign eff_en = en;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        wrap_d  = 1'b0;
        if (load) begin
            q_d     = WIDTH'(clamp_load(33'(load_val), 33'(MODULUS)));
            state_d = RUN;
        end else if (eff_en && state_q == RUN) begin
            if (at_terminal && oneshot) begin
                state_d = HALT;
            end else begin
                q_d    = next_q;
                wrap_d = at_terminal;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            q_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign done = (state_q == HALT);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod (WIDTH=4, MODULUS=10).
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst, en, up, load, oneshot;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       wrap, done;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

`ifdef UPDOWN_COUNTER_CASCADE_EN
    logic       cin;
    logic       cout;
    logic       c_rst;
    logic [3:0] u_q, t_q;
    logic       u_wrap, u_done, u_cout, t_wrap, t_done, t_cout;
`endif

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .oneshot(oneshot), .q(q), .wrap(wrap), .done(done)
`ifdef UPDOWN_COUNTER_CASCADE_EN
        , .cin(cin), .cout(cout)
`endif
    );

`ifdef UPDOWN_COUNTER_CASCADE_EN
    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_units (
        .clk(clk), .rst(c_rst), .en(1'b1), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(u_q), .wrap(u_wrap), .done(u_done), .cin(1'b1), .cout(u_cout)
    );
    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_tens (
        .clk(clk), .rst(c_rst), .en(1'b1), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .oneshot(1'b0), .q(t_q), .wrap(t_wrap), .done(t_done), .cin(u_cout), .cout(t_cout)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int eq, input bit ew, input bit ed);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; oneshot = 1'b0;
`ifdef UPDOWN_COUNTER_CASCADE_EN
        cin = 1'b1; c_rst = 1'b1;
`endif
        step();
        check_out("reset", 0, 1'b0, 1'b0);

        // Count to 7, then reset mid-count
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (7) step();
        check("count_to_7.q", 32'(q), 32'd7);
        rst = 1'b1;
        step();
        check_out("reset_mid_count", 0, 1'b0, 1'b0);

        // Free-run up across the wrap
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_out($sformatf("up_run%0d", i), exp_up[i], exp_up[i] == 0, 1'b0);
        end

        // Free-run down wrap from 0
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        check_out("load0", 0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check_out("down_wrap", 9, 1'b1, 1'b0);
        step();
        check_out("down_after_wrap", 8, 1'b0, 1'b0);

        // Hold with en=0
        en = 1'b0;
        step();
        check_out("hold", 8, 1'b0, 1'b0);

        // Load beats enable and is clamped
        load = 1'b1; load_val = 4'd13; en = 1'b1; up = 1'b1;
        step();
        check_out("load_clamp", 9, 1'b0, 1'b0);

        // Direction change takes effect on the next enabled edge
        load_val = 4'd5;
        step();
        load = 1'b0;
        step();
        check("dir_up.q", 32'(q), 32'd6);
        up = 1'b0;
        step();
        check("dir_down.q", 32'(q), 32'd5);

        // One-shot up halt
        oneshot = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
        step();
        check_out("os_load7", 7, 1'b0, 1'b0);
        load = 1'b0;
        step();
        check_out("os_8", 8, 1'b0, 1'b0);
        step();
        check_out("os_9", 9, 1'b0, 1'b0);
        step();
        check_out("os_halt", 9, 1'b0, 1'b1);
        step();
        check_out("os_frozen", 9, 1'b0, 1'b1);
        oneshot = 1'b0;
        step();
        check_out("os_clear_stays_halted", 9, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd3;
        step();
        check_out("os_reload", 3, 1'b0, 1'b0);

        // One-shot down halt, released by reset
        oneshot = 1'b1; up = 1'b0; load_val = 4'd1;
        step();
        load = 1'b0;
        step();
        check_out("osd_0", 0, 1'b0, 1'b0);
        step();
        check_out("osd_halt", 0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check_out("osd_reset", 0, 1'b0, 1'b0);

        // Reset wins over a simultaneous load
        load = 1'b1; load_val = 4'd6;
        step();
        check_out("reset_mid_load", 0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0; oneshot = 1'b0; en = 1'b0;

`ifdef UPDOWN_COUNTER_CASCADE_EN
        // Two-digit BCD chain: units -> tens
        step();
        c_rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step();
            check($sformatf("bcd%0d", i), 32'(t_q) * 10 + 32'(u_q), 32'(i % 100));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
